bulk_line_axi_bridge: RTL and testbench
=======================================

Name: bulk_line_axi_bridge

Overview:
Parametrised successor to the single-line bulk-to-AXI adapter. Converts one cache-line bulk request (read or write) from the bulk_read_interface into a single AXI4 INCR burst, with correct burst encoding, WLAST generation, write-response wait and error reporting. Sits between the cache/line-fill logic and the AXI interconnect.

Parameters:
LINE_BEATS, 8, beats per line; power of two, 2..256; drives arlen/awlen = LINE_BEATS-1.
DATA_W, 64, AXI data width in bits; power of two, >= 8; arsize/awsize = $clog2(DATA_W/8).
ADDR_W, 32, address width.
AXI_ID, 1, constant ID driven on arid/awid.

Ports:
clk  input  1  clock.
rst  input  1  synchronous active-high reset.
bulk_in  bulk_read_interface.slave  intf  line requests and responses: req_valid/ready/write/addr/wdata/wstrb, resp_valid/rdata.
axi_rd  axi_interface_if.rd_mst  intf  AXI read address and read data channels.
axi_wr  axi_interface_if.wr_mst  intf  AXI write address, write data and write response channels.
resp_err  output  1  valid with resp_valid; 1 = AXI error or protocol mismatch on this line.
busy  output  1  high whenever state != IDLE.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- Reset: state IDLE; beat counter 0; arvalid, awvalid, wvalid, wlast, resp_valid, resp_err, busy all 0; line buffer and strobe buffer cleared. rready = bready = 1 at all times. A reset mid-burst drops the transaction; the AXI slave shares rst.
- States: IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - req_ready = 1, independent of arready/awready.
  - On req_valid && req_ready, capture the line-aligned address: low $clog2(LINE_BEATS*DATA_W/8) bits cleared.
  - Read: go to RD_ADDR.
  - Write: also capture wdata and wstrb; clear aw_done; go to WR_DATA.
- RD_ADDR:
  - arvalid = 1 with araddr = aligned address, arlen = LINE_BEATS-1, arsize per DATA_W, arburst = 2'b01 (INCR), arid = AXI_ID, other fields 0.
  - On arready, go to RD_DATA with beat = 0.
- RD_DATA:
  - Each rvalid handshake stores rdata into buffer[beat] and increments beat.
  - beat counter is $clog2(LINE_BEATS)+1 bits wide and never wraps.
  - On the handshake with beat == LINE_BEATS-1, go to IDLE.
  - resp_valid is a 1-cycle pulse on the following cycle; resp_rdata is stable from that pulse until the next request is accepted.
  - resp_err = OR over the burst of (rresp != OKAY), or rlast mismatch (rlast on a non-final beat, or absent on the final beat).
  - Completion is by beat count only; early rlast does not end the burst.
- WR_DATA:
  - awvalid stays high until awready, then aw_done = 1.
  - In parallel, wvalid = 1 with wdata/wstrb = buffer[beat]; wlast = 1 when beat == LINE_BEATS-1; beat increments on each wready.
  - AW and W are independent: all W beats may complete before awready.
  - Leave for WR_RESP once aw_done and all beats are sent, including the case where both finish in the same cycle.
- WR_RESP: wait for bvalid. Next cycle: resp_valid pulse, resp_err = (bresp != OKAY), return to IDLE.
- Latency:
  - Read: zero-wait slave gives arvalid 1 cycle after acceptance and resp_valid 1 cycle after the last R beat.
  - Write: resp_valid 1 cycle after the B handshake.
- Only one line is outstanding at a time; req_ready = 0 in every non-IDLE state.

Optional Feature:
BULK_AXI_ERR_LOG_EN
- Defined: adds ports err_sticky (output, 1), err_addr (output, ADDR_W) and err_clr (input, 1).
  - The first erroring line sets err_sticky and captures its aligned address. Later errors do not overwrite it while sticky.
  - err_clr clears err_sticky. If err_clr and a new error occur in the same cycle, the new error wins and its address is captured.
  - Both outputs reset to 0.
- Undefined: these ports and registers are absent; resp_err is unchanged.

Decomposition:
- Package bulk_axi_pkg holds:
  - the state enum;
  - AXI_BURST_INCR = 2'b01;
  - AXI_RESP_OKAY = 2'b00;
  - a function axi_size(DATA_W) returning the size encoding.
- One natural sub-module: bulk_axi_wr_chan, holding the AW/W independent handshake, aw_done flag, beat counter and wlast.

Test Plan:
1. Read, zero-wait slave, LINE_BEATS=8, addr 0x1038 -> araddr 0x1000, arlen 7, arsize 3, arburst 01; 8 beats stored in order; resp_valid 1 cycle after the 8th beat; resp_err 0.
2. Read with arready delayed 5 cycles and rvalid gaps -> arvalid held stable; beats counted only on handshakes; correct data; busy high throughout.
3. Write where awready is held low until all 8 W beats are accepted -> wlast only on beat 7; WR_RESP entered after awready; resp_valid 1 cycle after bvalid.
4. Write with bresp=SLVERR -> resp_err 1 with resp_valid; with BULK_AXI_ERR_LOG_EN, err_sticky 1 and err_addr = line address.
5. Read with rlast on beat 5 -> burst still completes after 8 beats; resp_err 1.
6. rst asserted mid-RD_DATA -> next cycle state IDLE, all valids 0, req_ready 1; a new read then completes normally.

Source files
------------

// File: rtl/bulk_axi_pkg.sv
// bulk_axi_pkg: shared types and constants for the bulk-line to AXI4 bridge.
// Contents: bridge state enum, AXI burst/response encodings, ID width and
// the AxSIZE helper. No ports.
package bulk_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_DATA,
    S_WR_RESP
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_ID_W       = 4;

  // AxSIZE = log2(bytes per beat); data_w is a power of two >= 8.
  function automatic logic [2:0] axi_size(input int data_w);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == data_w) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_interface_if.sv
// axi_interface_if: AXI4 read and write channels (subset used by the bridge).
// Modports: rd_mst (AR + R, master side), wr_mst (AW + W + B, master side).
interface axi_interface_if
  import bulk_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [AXI_ID_W-1:0] arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [AXI_ID_W-1:0] awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport rd_mst (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport wr_mst (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/bulk_read_interface.sv
// bulk_read_interface: one-line request/response channel from the cache side.
// Signals: req_valid/req_ready handshake, req_write, req_addr, full-line
// req_wdata/req_wstrb, and a resp_valid pulse with full-line resp_rdata.
// Modports: slave (bridge side), master (requester side).
interface bulk_read_interface #(
  parameter int LINE_BEATS = 8,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32
);
  localparam int LINE_W = LINE_BEATS * DATA_W;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [LINE_W-1:0]   req_wdata;
  logic [LINE_W/8-1:0] req_wstrb;
  logic                resp_valid;
  logic [LINE_W-1:0]   resp_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/bulk_axi_wr_chan.sv
// bulk_axi_wr_chan: AW/W sequencing for one write burst.
// Ports: clk, rst (sync, active high); start loads a new line; active is high
// in WR_DATA; awready/wready from the slave; awvalid, wvalid, wlast to AXI;
// beat_idx selects the buffered beat; done is high in the cycle both the
// address and the final data beat have been (or are being) accepted.
module bulk_axi_wr_chan #(
  parameter int LINE_BEATS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          active,
  input  logic                          awready,
  input  logic                          wready,
  output logic                          awvalid,
  output logic                          wvalid,
  output logic                          wlast,
  output logic [$clog2(LINE_BEATS)-1:0] beat_idx,
  output logic                          done
);
  localparam int BEAT_W = $clog2(LINE_BEATS) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [BEAT_W-1:0] ALL_BEATS = BEAT_W'(LINE_BEATS);

  logic [BEAT_W-1:0] beat_q;
  logic              aw_done;
  logic              aw_fin;
  logic              w_fin;

  assign awvalid  = active && !aw_done;
  assign wvalid   = active && (beat_q != ALL_BEATS);
  assign wlast    = wvalid && (beat_q == LAST_BEAT);
  assign beat_idx = beat_q[BEAT_W-2:0];

  // Either side may finish first; both may finish in the same cycle.
  assign aw_fin = aw_done || (awvalid && awready);
  assign w_fin  = !wvalid || (wready && wlast);
  assign done   = active && aw_fin && w_fin;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      aw_done <= 1'b0;
    end else if (start) begin
      beat_q  <= '0;
      aw_done <= 1'b0;
    end else if (active) begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   beat_q  <= beat_q + 1'b1;
    end
  end
endmodule

// File: rtl/bulk_line_axi_bridge.sv
// bulk_line_axi_bridge: turns one bulk line request into one AXI4 INCR burst.
// Ports: clk, rst (sync, active high); bulk_in (line request/response);
// axi_rd (AR/R master); axi_wr (AW/W/B master); resp_err (qualified by
// resp_valid); busy (not idle).
// Optional build macro BULK_AXI_ERR_LOG_EN adds err_clr (in), err_sticky and
// err_addr (out): a sticky record of the first failing line address.
//
// state     | meaning
// S_IDLE    | ready for a request
// S_RD_ADDR | AR presented, waiting for arready
// S_RD_DATA | collecting R beats into the line buffer
// S_WR_DATA | AW and W beats in flight independently
// S_WR_RESP | waiting for the B response
module bulk_line_axi_bridge
  import bulk_axi_pkg::*;
#(
  parameter int LINE_BEATS = 8,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int AXI_ID     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bulk_read_interface.slave     bulk_in,
  axi_interface_if.rd_mst       axi_rd,
  axi_interface_if.wr_mst       axi_wr,
  output logic                  resp_err,
  output logic                  busy
`ifdef BULK_AXI_ERR_LOG_EN
  ,
  input  logic                  err_clr,
  output logic                  err_sticky,
  output logic [ADDR_W-1:0]     err_addr
`endif
);
  localparam int LINE_W  = LINE_BEATS * DATA_W;
  localparam int BEAT_W  = $clog2(LINE_BEATS) + 1;
  localparam int ALIGN_W = $clog2(LINE_BEATS * DATA_W / 8);
  localparam int STRB_W  = DATA_W / 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_W) - ADDR_W'(1));

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         line_addr;
  logic [LINE_W-1:0]         line_buf;
  logic [LINE_W/8-1:0]       strb_buf;
  logic [BEAT_W-1:0]         rd_beat;
  logic [BEAT_W-2:0]         rd_idx;
  logic                      rd_err;
  logic                      resp_valid_q, resp_err_q;
  logic                      accept, r_hs, r_last, r_beat_err;
  logic                      wr_start, wr_active, wr_done;
  logic [$clog2(LINE_BEATS)-1:0] wr_idx;

  assign accept     = (state_q == S_IDLE) && bulk_in.req_valid;
  assign r_hs       = (state_q == S_RD_DATA) && axi_rd.rvalid;
  assign r_last     = (rd_beat == LAST_BEAT);
  assign rd_idx     = rd_beat[BEAT_W-2:0];
  // rlast must coincide exactly with the final counted beat.
  assign r_beat_err = (axi_rd.rresp != AXI_RESP_OKAY) || (axi_rd.rlast != r_last);
  assign wr_start   = accept && bulk_in.req_write;
  assign wr_active  = (state_q == S_WR_DATA);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    bulk_in.req_ready  = 1'b0;
    axi_rd.arvalid     = 1'b0;
    busy               = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        bulk_in.req_ready = 1'b1;
        busy              = 1'b0;
        if (bulk_in.req_valid) state_d = bulk_in.req_write ? S_WR_DATA : S_RD_ADDR;
      end
      S_RD_ADDR: begin
        axi_rd.arvalid = 1'b1;
        if (axi_rd.arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: if (r_hs && r_last) state_d = S_IDLE;
      S_WR_DATA: if (wr_done)        state_d = S_WR_RESP;
      S_WR_RESP: if (axi_wr.bvalid)  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr    <= '0;
      line_buf     <= '0;
      strb_buf     <= '0;
      rd_beat      <= '0;
      rd_err       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (accept) begin
        line_addr <= bulk_in.req_addr & ALIGN_MASK;
        if (bulk_in.req_write) begin
          line_buf <= bulk_in.req_wdata;
          strb_buf <= bulk_in.req_wstrb;
        end
      end
      if ((state_q == S_RD_ADDR) && axi_rd.arready) begin
        rd_beat <= '0;
        rd_err  <= 1'b0;
      end
      if (r_hs) begin
        line_buf[int'(rd_idx)*DATA_W +: DATA_W] <= axi_rd.rdata;
        rd_beat <= rd_beat + 1'b1;
        rd_err  <= rd_err | r_beat_err;
        if (r_last) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= rd_err | r_beat_err;
        end
      end
      if ((state_q == S_WR_RESP) && axi_wr.bvalid) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= (axi_wr.bresp != AXI_RESP_OKAY);
      end
    end
  end

  assign bulk_in.resp_valid = resp_valid_q;
  assign bulk_in.resp_rdata = line_buf;
  assign resp_err           = resp_valid_q & resp_err_q;

  assign axi_rd.arid    = AXI_ID_W'(AXI_ID);
  assign axi_rd.araddr  = line_addr;
  assign axi_rd.arlen   = 8'(LINE_BEATS - 1);
  assign axi_rd.arsize  = axi_size(DATA_W);
  assign axi_rd.arburst = AXI_BURST_INCR;
  assign axi_rd.arlock  = 1'b0;
  assign axi_rd.arcache = 4'd0;
  assign axi_rd.arprot  = 3'd0;
  assign axi_rd.rready  = 1'b1;

  bulk_axi_wr_chan #(.LINE_BEATS(LINE_BEATS)) u_wr_chan (
    .clk      (clk),
    .rst      (rst),
    .start    (wr_start),
    .active   (wr_active),
    .awready  (axi_wr.awready),
    .wready   (axi_wr.wready),
    .awvalid  (axi_wr.awvalid),
    .wvalid   (axi_wr.wvalid),
    .wlast    (axi_wr.wlast),
    .beat_idx (wr_idx),
    .done     (wr_done)
  );

  assign axi_wr.awid    = AXI_ID_W'(AXI_ID);
  assign axi_wr.awaddr  = line_addr;
  assign axi_wr.awlen   = 8'(LINE_BEATS - 1);
  assign axi_wr.awsize  = axi_size(DATA_W);
  assign axi_wr.awburst = AXI_BURST_INCR;
  assign axi_wr.awlock  = 1'b0;
  assign axi_wr.awcache = 4'd0;
  assign axi_wr.awprot  = 3'd0;
  assign axi_wr.wdata   = line_buf[int'(wr_idx)*DATA_W +: DATA_W];
  assign axi_wr.wstrb   = strb_buf[int'(wr_idx)*STRB_W +: STRB_W];
  assign axi_wr.bready  = 1'b1;

`ifdef BULK_AXI_ERR_LOG_EN
  // line_addr still holds the finished line during its response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (resp_err && (!err_sticky || err_clr)) begin
      err_sticky <= 1'b1;
      err_addr   <= line_addr;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_bulk_line_axi_bridge.sv
`timescale 1ns/1ps
module tb_bulk_line_axi_bridge;
  localparam int LB  = 8;
  localparam int DW  = 64;
  localparam int AWD = 32;
  localparam int LW  = LB * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resp_err, busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic             exp_sticky = 1'b0;
  logic [AWD-1:0]   exp_eaddr  = '0;

  always #5 clk = ~clk;

  bulk_read_interface #(.LINE_BEATS(LB), .DATA_W(DW), .ADDR_W(AWD)) bulk ();
  axi_interface_if    #(.ADDR_W(AWD), .DATA_W(DW)) axi ();

`ifdef BULK_AXI_ERR_LOG_EN
  logic           err_clr = 1'b0;
  logic           err_sticky;
  logic [AWD-1:0] err_addr;
`endif

  bulk_line_axi_bridge #(.LINE_BEATS(LB), .DATA_W(DW), .ADDR_W(AWD), .AXI_ID(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bulk_in  (bulk),
    .axi_rd   (axi),
    .axi_wr   (axi),
    .resp_err (resp_err),
    .busy     (busy)
`ifdef BULK_AXI_ERR_LOG_EN
    ,
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .err_addr   (err_addr)
`endif
  );

  task automatic chk_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AWD-1:0] line_of(input logic [AWD-1:0] a);
    return a & ~AWD'(LW / 8 - 1);
  endfunction

  // Cycle after a response pulse: pulse gone, error log updated.
  task automatic line_end(input logic err, input logic [AWD-1:0] aligned);
    tick();
    chk_eq("resp_pulse_len", bulk.resp_valid, 1'b0);
`ifdef BULK_AXI_ERR_LOG_EN
    if (err && !exp_sticky) begin
      exp_sticky = 1'b1;
      exp_eaddr  = aligned;
    end
    chk_eq("err_sticky", err_sticky, exp_sticky);
    if (exp_sticky) chk_eq("err_addr", err_addr, exp_eaddr);
`else
    if (err && aligned === 'x) chk_eq("unreachable", 1'b0, 1'b1);
`endif
  endtask

  task automatic rd_line(input logic [AWD-1:0] addr, input int ar_wait, input int gap,
                         input int bad_beat, input int last_beat, input int rst_beat);
    logic [DW-1:0]  beats [LB];
    logic [LW-1:0]  exp_line;
    logic [AWD-1:0] aligned;
    logic exp_err, ar_done, ar_hs, r_hs, steady, done;
    int beat, cyc;
    aligned = line_of(addr);
    exp_err = (bad_beat >= 0) || (last_beat != LB - 1);
    for (int i = 0; i < LB; i++) begin
      beats[i] = {$urandom, $urandom};
      exp_line[i*DW +: DW] = beats[i];
    end
    chk_eq("rd_req_ready", bulk.req_ready, 1'b1);
    bulk.req_valid = 1'b1;
    bulk.req_write = 1'b0;
    bulk.req_addr  = addr;
    tick();
    bulk.req_valid = 1'b0;
    chk_eq("rd_ar_latency", axi.arvalid, 1'b1);
    chk_eq("rd_araddr", axi.araddr, aligned);
    chk_eq("rd_arlen", axi.arlen, 8'(LB - 1));
    chk_eq("rd_arsize", axi.arsize, 3'd3);
    chk_eq("rd_arburst", axi.arburst, 2'b01);
    chk_eq("rd_arid", axi.arid, 4'd1);
    chk_eq("rd_ar_other", {axi.arlock, axi.arcache, axi.arprot}, 8'd0);
    beat = 0; cyc = 0; ar_done = 1'b0; steady = 1'b1; done = 1'b0;
    while (!done && cyc < 300) begin
      axi.arready = !ar_done && (cyc >= ar_wait);
      axi.rvalid  = ar_done && (beat < LB) && ($urandom_range(99) >= gap);
      axi.rdata   = beats[beat % LB];
      axi.rresp   = (beat == bad_beat) ? 2'b10 : 2'b00;
      axi.rlast   = (beat == last_beat);
      if (!ar_done && !(axi.arvalid === 1'b1 && axi.araddr === aligned)) steady = 1'b0;
      if (busy !== 1'b1 || bulk.req_ready !== 1'b0 || bulk.resp_valid !== 1'b0) steady = 1'b0;
      ar_hs = axi.arvalid && axi.arready;
      r_hs  = axi.rvalid && axi.rready;
      if (rst_beat >= 0 && ar_done && beat == rst_beat) rst = 1'b1;
      tick();
      cyc++;
      if (rst) begin
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_req_ready", bulk.req_ready, 1'b1);
        chk_eq("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, bulk.resp_valid}, 4'd0);
        rst = 1'b0;
        axi.rvalid  = 1'b0;
        axi.arready = 1'b0;
        return;
      end
      if (ar_hs) ar_done = 1'b1;
      if (r_hs) begin
        beat++;
        if (beat == LB) done = 1'b1;
      end
    end
    axi.rvalid = 1'b0; axi.arready = 1'b0; axi.rlast = 1'b0;
    chk_eq("rd_done", done, 1'b1);
    chk_eq("rd_steady_busy", steady, 1'b1);
    if (ar_wait == 0 && gap == 0) chk_eq("rd_latency", cyc, LB + 1);
    chk_eq("rd_resp_valid", bulk.resp_valid, 1'b1);
    chk_eq("rd_resp_err", resp_err, exp_err);
    chk_eq("rd_rdata", bulk.resp_rdata, exp_line);
    chk_eq("rd_busy_end", busy, 1'b0);
    line_end(exp_err, aligned);
    chk_eq("rd_rdata_hold", bulk.resp_rdata, exp_line);
  endtask

  task automatic wr_line(input logic [AWD-1:0] addr, input int aw_wait, input int gap,
                         input logic [1:0] bresp, input int b_wait);
    logic [LW-1:0]   wd, got_d;
    logic [LW/8-1:0] ws, got_s;
    logic [AWD-1:0]  aligned;
    logic aw_seen, aw_ok, wlast_ok, steady, done, phase_b, aw_hs, w_hs, b_hs;
    int wbeat, cyc, bcnt;
    aligned = line_of(addr);
    for (int i = 0; i < LB; i++) begin
      wd[i*DW +: DW] = {$urandom, $urandom};
      ws[i*8 +: 8]   = 8'($urandom);
    end
    got_d = '0; got_s = '0;
    chk_eq("wr_req_ready", bulk.req_ready, 1'b1);
    bulk.req_valid = 1'b1;
    bulk.req_write = 1'b1;
    bulk.req_addr  = addr;
    bulk.req_wdata = wd;
    bulk.req_wstrb = ws;
    tick();
    bulk.req_valid = 1'b0;
    bulk.req_wdata = ~wd;
    bulk.req_wstrb = ~ws;
    wbeat = 0; cyc = 0; bcnt = 0;
    aw_seen = 0; aw_ok = 1; wlast_ok = 1; steady = 1; done = 0; phase_b = 0;
    while (!done && cyc < 300) begin
      axi.awready = !aw_seen && (cyc >= aw_wait);
      axi.wready  = ($urandom_range(99) >= gap);
      axi.bvalid  = phase_b && (bcnt >= b_wait);
      axi.bresp   = bresp;
      if (axi.awvalid === 1'b1 &&
          (axi.awaddr !== aligned || axi.awlen !== 8'(LB - 1) || axi.awsize !== 3'd3 ||
           axi.awburst !== 2'b01 || axi.awid !== 4'd1 ||
           {axi.awlock, axi.awcache, axi.awprot} !== 8'd0)) aw_ok = 1'b0;
      if (!aw_seen && axi.awvalid !== 1'b1) steady = 1'b0;
      if (wbeat >= LB && axi.wvalid !== 1'b0) steady = 1'b0;
      if (phase_b && (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0)) steady = 1'b0;
      if (busy !== 1'b1 || bulk.req_ready !== 1'b0 || bulk.resp_valid !== 1'b0) steady = 1'b0;
      if (axi.wvalid === 1'b1 && wbeat < LB && axi.wlast !== (wbeat == LB - 1)) wlast_ok = 1'b0;
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      b_hs  = axi.bvalid && axi.bready;
      if (w_hs && wbeat < LB) begin
        got_d[wbeat*DW +: DW] = axi.wdata;
        got_s[wbeat*8 +: 8]   = axi.wstrb;
      end
      tick();
      cyc++;
      if (aw_hs) aw_seen = 1'b1;
      if (w_hs) wbeat++;
      if (phase_b) bcnt++;
      if (b_hs) done = 1'b1;
      if (aw_seen && wbeat >= LB) phase_b = 1'b1;
    end
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
    chk_eq("wr_done", done, 1'b1);
    chk_eq("wr_aw_fields", aw_ok, 1'b1);
    chk_eq("wr_wlast", wlast_ok, 1'b1);
    chk_eq("wr_steady_busy", steady, 1'b1);
    chk_eq("wr_beats", wbeat, LB);
    chk_eq("wr_wdata", got_d, wd);
    chk_eq("wr_wstrb", got_s, ws);
    if (aw_wait == 0 && gap == 0 && b_wait == 0) chk_eq("wr_latency", cyc, LB + 1);
    chk_eq("wr_resp_valid", bulk.resp_valid, 1'b1);
    chk_eq("wr_resp_err", resp_err, bresp != 2'b00);
    chk_eq("wr_busy_end", busy, 1'b0);
    line_end(bresp != 2'b00, aligned);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bulk.req_valid = 0; bulk.req_write = 0; bulk.req_addr = '0;
    bulk.req_wdata = '0; bulk.req_wstrb = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_eq("reset_req_ready", bulk.req_ready, 1'b1);
    chk_eq("reset_busy", busy, 1'b0);
    chk_eq("reset_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.wlast, bulk.resp_valid, resp_err}, 6'd0);
    chk_eq("reset_ready_tieoffs", {axi.rready, axi.bready}, 2'b11);
    chk_eq("reset_rdata", bulk.resp_rdata, '0);
`ifdef BULK_AXI_ERR_LOG_EN
    chk_eq("reset_err_log", {err_sticky, err_addr}, '0);
`endif

    rd_line(32'h0000_1038, 0, 0, -1, LB - 1, -1);      // aligned read, zero wait
    rd_line(32'h0000_2A10, 5, 40, -1, LB - 1, -1);     // AR stall, R gaps
    wr_line(32'h0000_3048, 12, 0, 2'b00, 0);           // all W before AW
    wr_line(32'h0000_4000, 0, 0, 2'b00, 0);            // zero-wait write
    wr_line(32'h0000_5078, 2, 20, 2'b10, 2);           // SLVERR
    rd_line(32'h0000_6000, 0, 0, -1, 5, -1);           // early rlast
    rd_line(32'h0000_7000, 0, 30, 3, LB - 1, -1);      // rresp error mid-burst
    rd_line(32'h0000_8000, 1, 0, -1, LB - 1, 3);       // reset mid-RD_DATA
    rd_line(32'h0000_8040, 0, 0, -1, LB - 1, -1);      // recovers after reset
`ifdef BULK_AXI_ERR_LOG_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_sticky = 1'b0;
    chk_eq("err_clr", err_sticky, 1'b0);
`endif

    for (int t = 0; t < 24; t++) begin
      logic [AWD-1:0] a;
      a = $urandom;
      if ($urandom_range(1) == 0)
        rd_line(a, $urandom_range(4), $urandom_range(50),
                ($urandom_range(9) == 0) ? int'($urandom_range(LB - 1)) : -1,
                ($urandom_range(4) == 0) ? int'($urandom_range(LB - 1)) : LB - 1, -1);
      else
        wr_line(a, $urandom_range(10), $urandom_range(50),
                ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                $urandom_range(3));
      repeat ($urandom_range(2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
